afe_roic_lvds_serializer: RTL and testbench

- Synthesizable, parametrised next generation of the ROIC LVDS output generator, used as an FPGA-side ROIC emulator and loopback source for receiver bring-up.
- Holds a small register file written through a simple config port.
- On each SYNC it serializes a multi-line frame of header+pixel words, MSB first, on NUM_CHANNELS data lanes, with a bit clock and a word frame clock.
- Pixel words come from a sensor-data input or an internal test-pattern generator.

---
 rtl/afe_roic_pkg.sv | 30 +++
 rtl/afe_roic_pattern_gen.sv | 102 ++++++++++
 rtl/afe_roic_lvds_serializer.sv | 221 ++++++++++++++++++++++
 tb/tb_afe_roic_lvds_serializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_roic_pkg.sv
// Shared definitions for the ROIC LVDS serializer: register map, pattern codes,
// FSM state type and the serial word width helper.
package afe_roic_pkg;

    // Register addresses
    localparam logic [7:0] REG_CTRL = 8'h00;  // data[0]: soft reset
    localparam logic [7:0] REG_PAT  = 8'h10;  // data[9:5]: pattern select
    localparam logic [7:0] REG_PWR  = 8'h13;  // data[15:5] all ones: sleep

    // Pattern codes
    localparam logic [4:0] PAT_NORMAL = 5'h00;
    localparam logic [4:0] PAT_ALT    = 5'h11;
    localparam logic [4:0] PAT_RAMP   = 5'h13;
    localparam logic [4:0] PAT_PRBS   = 5'h15;
    localparam logic [4:0] PAT_ZEROS  = 5'h17;
    localparam logic [4:0] PAT_ONES   = 5'h19;
    localparam logic [4:0] PAT_DESKEW = 5'h1E;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    function automatic int unsigned word_width(input int unsigned header_w,
                                               input int unsigned pixel_w);
        return header_w + pixel_w;
    endfunction

endpackage

// File: rtl/afe_roic_pattern_gen.sv
// Per-lane word builder. Produces the {header, pixel} word to load into a lane's
// shift register for the selected pattern.
// Ports:
//   pattern      pattern select code
//   lane         lane index (constant per instance)
//   pixel_cnt    index of the word being loaded within the line
//   line_cnt     line index of the word being loaded (header width/2 bits)
//   sensor_pixel sensor data for this lane
//   tp_sel       external test-pattern request (NORMAL mode only)
//   word         assembled serial word
//   clk/rst_n/seed_load/advance exist only with AFE_ROIC_PRBS_EN (PRBS-15 LFSR).
module afe_roic_pattern_gen
    import afe_roic_pkg::*;
#(
    parameter int unsigned PIXEL_W  = 16,
    parameter int unsigned HEADER_W = 8
) (
`ifdef AFE_ROIC_PRBS_EN
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         seed_load,
    input  logic                         advance,
`endif
    input  logic [4:0]                   pattern,
    input  logic [3:0]                   lane,
    input  logic [PIXEL_W-1:0]           pixel_cnt,
    input  logic [HEADER_W/2-1:0]        line_cnt,
    input  logic [PIXEL_W-1:0]           sensor_pixel,
    input  logic                         tp_sel,
    output logic [HEADER_W+PIXEL_W-1:0]  word
);

    localparam int unsigned HW2 = HEADER_W / 2;

    logic [HEADER_W-1:0] hdr;
    logic [PIXEL_W-1:0]  pix;

`ifdef AFE_ROIC_PRBS_EN
    logic [14:0]        lfsr_q, lfsr_cur, lfsr_nxt;
    logic [PIXEL_W-1:0] prbs_pix;

    // x^15 + x^14 + 1, first generated bit lands in the pixel MSB.
    always_comb begin
        lfsr_cur = seed_load ? (15'(lane) + 15'd1) : lfsr_q;
        lfsr_nxt = lfsr_cur;
        prbs_pix = '0;
        for (int b = PIXEL_W - 1; b >= 0; b--) begin
            prbs_pix[b] = lfsr_nxt[14] ^ lfsr_nxt[13];
            lfsr_nxt    = {lfsr_nxt[13:0], prbs_pix[b]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 15'd1;
        end else if (advance) begin
            lfsr_q <= lfsr_nxt;
        end
    end
`endif

    always_comb begin
        hdr = {HW2'(lane), line_cnt};
        pix = sensor_pixel;
        case (pattern)
            PAT_ALT: begin
                for (int b = 0; b < int'(HEADER_W); b++) hdr[b] = (b % 2 == 0);
                for (int b = 0; b < int'(PIXEL_W); b++) pix[b] = (b % 2 == 1);
            end
            PAT_RAMP: begin
                pix = pixel_cnt + PIXEL_W'({lane, 8'h00});
            end
            PAT_ZEROS: begin
                hdr = '0;
                pix = '0;
            end
            PAT_ONES: begin
                hdr = '1;
                pix = '1;
            end
            PAT_DESKEW: begin
                for (int b = 0; b < int'(HEADER_W); b++) hdr[b] = (b % 2 == 1);
                for (int b = 0; b < int'(PIXEL_W); b++) pix[b] = (b >= int'(PIXEL_W / 4));
            end
`ifdef AFE_ROIC_PRBS_EN
            PAT_PRBS: begin
                hdr = {HW2'(lane), {HW2{1'b0}}};
                pix = prbs_pix;
            end
`endif
            default: begin
                // NORMAL and any unknown code
                if (tp_sel) begin
                    hdr = {HW2'(lane), {HW2{1'b0}}};
                    pix = pixel_cnt + PIXEL_W'(lane);
                end
            end
        endcase
        word = {hdr, pix};
    end

endmodule

// File: rtl/afe_roic_lvds_serializer.sv
// ROIC LVDS output emulator. On each accepted SYNC rising edge it serializes a
// frame of LINES_PER_FRAME lines, each PIXELS_PER_LINE words of {header, pixel},
// MSB first on every lane, with a DDR bit clock and a word frame clock.
// Ports:
//   clk, rst_n          bit clock, async active-low reset
//   sync_i              frame trigger (rising edge)
//   tp_sel_i            test-pattern request in NORMAL mode
//   cfg_wr_i/addr/data  register write port
//   sensor_data_i       per-lane pixel input, lane 0 in LSBs
//   sensor_req_o        sensor_data_i is sampled this cycle
//   dout_o/dclk_o/fclk_o serial data, bit clock, word clock
//   frame_active_o, line_cnt_o, frame_cnt_o, sync_err_o, sleep_o  status
// Optional: define AFE_ROIC_PRBS_EN to build the PRBS-15 pattern (code 0x15).
module afe_roic_lvds_serializer
    import afe_roic_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS    = 14,
    parameter int unsigned PIXEL_W         = 16,
    parameter int unsigned HEADER_W        = 8,
    parameter int unsigned PIXELS_PER_LINE = 256,
    parameter int unsigned LINES_PER_FRAME = 1,
    parameter int unsigned LINE_GAP        = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sync_i,
    input  logic                              tp_sel_i,
    input  logic                              cfg_wr_i,
    input  logic [7:0]                        cfg_addr_i,
    input  logic [15:0]                       cfg_data_i,
    input  logic [NUM_CHANNELS*PIXEL_W-1:0]   sensor_data_i,
    output logic                              sensor_req_o,
    output logic [NUM_CHANNELS-1:0]           dout_o,
    output logic                              dclk_o,
    output logic                              fclk_o,
    output logic                              frame_active_o,
    output logic [15:0]                       line_cnt_o,
    output logic [15:0]                       frame_cnt_o,
    output logic                              sync_err_o,
    output logic                              sleep_o
);

    localparam int unsigned W = word_width(HEADER_W, PIXEL_W);

    state_e      state_q, state_d;
    logic        sync_q;
    logic [4:0]  pat_q, pat_d;
    logic        sleep_q, sleep_d;
    logic [15:0] bit_q, bit_d, word_q, word_d, line_q, line_d;
    logic [15:0] gap_q, gap_d, frame_q, frame_d;
    logic        dclk_q, dclk_d;
    logic        sync_edge, soft_rst, load, sync_err;
    logic [W-1:0] shreg_q [NUM_CHANNELS];
    logic [W-1:0] shreg_d [NUM_CHANNELS];
    logic [W-1:0] load_word [NUM_CHANNELS];

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data_i[4:1];

    // word_d/line_d carry the pixel and line index of the word being loaded.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        afe_roic_pattern_gen #(
            .PIXEL_W  (PIXEL_W),
            .HEADER_W (HEADER_W)
        ) u_gen (
`ifdef AFE_ROIC_PRBS_EN
            .clk          (clk),
            .rst_n        (rst_n),
            .seed_load    (state_q == StIdle),
            .advance      (load),
`endif
            .pattern      (pat_q),
            .lane         (4'(i)),
            .pixel_cnt    (PIXEL_W'(word_d)),
            .line_cnt     (line_d[HEADER_W/2-1:0]),
            .sensor_pixel (sensor_data_i[i*PIXEL_W +: PIXEL_W]),
            .tp_sel       (tp_sel_i),
            .word         (load_word[i])
        );
    end

    always_comb begin
        sync_edge = sync_i & ~sync_q;
        soft_rst  = cfg_wr_i && (cfg_addr_i == REG_CTRL) && cfg_data_i[0];
        state_d   = state_q;
        bit_d     = bit_q;
        word_d    = word_q;
        line_d    = line_q;
        gap_d     = gap_q;
        frame_d   = frame_q;
        dclk_d    = dclk_q;
        pat_d     = pat_q;
        sleep_d   = sleep_q;
        load      = 1'b0;
        sync_err  = 1'b0;

        if (cfg_wr_i && (cfg_addr_i == REG_PAT)) pat_d = cfg_data_i[9:5];
        if (cfg_wr_i && (cfg_addr_i == REG_PWR)) sleep_d = &cfg_data_i[15:5];

        unique case (state_q)
            StIdle: begin
                if (sync_edge) begin
                    if (sleep_q) begin
                        sync_err = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = StShift;
                        bit_d   = '0;
                        word_d  = '0;
                        line_d  = '0;
                        dclk_d  = 1'b1;
                    end
                end
            end
            StShift: begin
                sync_err = sync_edge;
                dclk_d   = ~dclk_q;
                bit_d    = bit_q + 16'd1;
                if (bit_q == 16'(W - 1)) begin
                    bit_d = '0;
                    if (word_q != 16'(PIXELS_PER_LINE - 1)) begin
                        load   = 1'b1;
                        word_d = word_q + 16'd1;
                    end else if (line_q != 16'(LINES_PER_FRAME - 1)) begin
                        state_d = StGap;
                        gap_d   = '0;
                        line_d  = line_q + 16'd1;
                    end else begin
                        state_d = StIdle;
                        dclk_d  = 1'b0;
                        frame_d = frame_q + 16'd1;
                    end
                end
            end
            StGap: begin
                // dclk holds here; the last gap cycle loads the next line's first word
                sync_err = sync_edge;
                gap_d    = gap_q + 16'd1;
                if (gap_q == 16'(LINE_GAP - 1)) begin
                    load    = 1'b1;
                    state_d = StShift;
                    word_d  = '0;
                    dclk_d  = ~dclk_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Soft reset wins over everything, including a coincident sync edge.
        if (soft_rst) begin
            state_d  = StIdle;
            bit_d    = '0;
            word_d   = '0;
            line_d   = '0;
            gap_d    = '0;
            frame_d  = '0;
            dclk_d   = 1'b0;
            pat_d    = PAT_NORMAL;
            sleep_d  = 1'b0;
            load     = 1'b0;
            sync_err = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            shreg_d[i] = shreg_q[i];
            if (soft_rst) begin
                shreg_d[i] = '0;
            end else if (load) begin
                shreg_d[i] = load_word[i];
            end else if (state_q == StShift) begin
                shreg_d[i] = {shreg_q[i][W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sync_q  <= 1'b0;
            pat_q   <= PAT_NORMAL;
            sleep_q <= 1'b0;
            bit_q   <= '0;
            word_q  <= '0;
            line_q  <= '0;
            gap_q   <= '0;
            frame_q <= '0;
            dclk_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_CHANNELS); i++) shreg_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_i;
            pat_q   <= pat_d;
            sleep_q <= sleep_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            line_q  <= line_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            dclk_q  <= dclk_d;
            for (int i = 0; i < int'(NUM_CHANNELS); i++) shreg_q[i] <= shreg_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            dout_o[i] = (state_q == StShift) & shreg_q[i][W-1];
        end
    end

    assign sensor_req_o   = load;
    assign sync_err_o     = sync_err;
    assign dclk_o         = dclk_q;
    assign fclk_o         = (state_q == StShift) && (bit_q < 16'(W / 2));
    assign frame_active_o = (state_q != StIdle);
    assign line_cnt_o     = line_q;
    assign frame_cnt_o    = frame_q;
    assign sleep_o        = sleep_q;

endmodule

// File: tb/tb_afe_roic_lvds_serializer.sv
module tb_afe_roic_lvds_serializer;

    localparam int NCH = 14;
    localparam int PW  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sync_i, sync2_i, tp_sel_i, cfg_wr_i;
    logic [7:0]      cfg_addr_i;
    logic [15:0]     cfg_data_i;
    logic [NCH*PW-1:0] sensor_data_i;

    logic            sensor_req_o, dclk_o, fclk_o, frame_active_o, sync_err_o, sleep_o;
    logic [NCH-1:0]  dout_o;
    logic [15:0]     line_cnt_o, frame_cnt_o;

    logic            sensor_req2, dclk2, fclk2, frame_active2, sync_err2, sleep2;
    logic [NCH-1:0]  dout2;
    logic [15:0]     line_cnt2, frame_cnt2;

    int checks = 0;
    int errors = 0;

    // Capture state filled by run_frame
    int          len, reqs, errs, fclk0, dclk_bad;
    logic [13:0] dout_first;
    logic [23:0] w_l0 [4];
    logic [23:0] w_l1 [4];
    int          dead;
    logic [15:0] line_first, line_last;

    always #5 clk = ~clk;

    afe_roic_lvds_serializer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sync_i         (sync_i),
        .tp_sel_i       (tp_sel_i),
        .cfg_wr_i       (cfg_wr_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_data_i     (cfg_data_i),
        .sensor_data_i  (sensor_data_i),
        .sensor_req_o   (sensor_req_o),
        .dout_o         (dout_o),
        .dclk_o         (dclk_o),
        .fclk_o         (fclk_o),
        .frame_active_o (frame_active_o),
        .line_cnt_o     (line_cnt_o),
        .frame_cnt_o    (frame_cnt_o),
        .sync_err_o     (sync_err_o),
        .sleep_o        (sleep_o)
    );

    afe_roic_lvds_serializer #(
        .LINES_PER_FRAME (2),
        .LINE_GAP        (4)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .sync_i         (sync2_i),
        .tp_sel_i       (tp_sel_i),
        .cfg_wr_i       (cfg_wr_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_data_i     (cfg_data_i),
        .sensor_data_i  (sensor_data_i),
        .sensor_req_o   (sensor_req2),
        .dout_o         (dout2),
        .dclk_o         (dclk2),
        .fclk_o         (fclk2),
        .frame_active_o (frame_active2),
        .line_cnt_o     (line_cnt2),
        .frame_cnt_o    (frame_cnt2),
        .sync_err_o     (sync_err2),
        .sleep_o        (sleep2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_wr_i   = 1'b1;
        cfg_addr_i = a;
        cfg_data_i = d;
        @(negedge clk);
        cfg_wr_i   = 1'b0;
    endtask

    task automatic start_sync1();
        @(negedge clk);
        sync_i = 1'b1;
        #1;
        chk("req_at_edge", {31'd0, sensor_req_o}, 32'd1);
        chk("idle_at_edge", {31'd0, frame_active_o}, 32'd0);
    endtask

    // Follows a dut frame from the cycle after the accepted edge until
    // frame_active_o falls. err_at: cycle of a second sync edge; abort_at: cycle of
    // a soft-reset write; tp_at: first cycle with tp_sel_i high (-1 = never).
    task automatic run_frame(input int err_at, input int abort_at, input int tp_at);
        len = 0; reqs = 1; errs = 0; fclk0 = 0; dclk_bad = 0; dout_first = '0;
        for (int k = 0; k < 4; k++) begin
            w_l0[k] = '0;
            w_l1[k] = '0;
        end
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            sync_i   = (c == err_at);
            tp_sel_i = (tp_at >= 0) && (c >= tp_at);
            if (c == abort_at) begin
                cfg_wr_i   = 1'b1;
                cfg_addr_i = 8'h00;
                cfg_data_i = 16'h0001;
            end else begin
                cfg_wr_i = 1'b0;
            end
            #1;
            if (!frame_active_o) break;
            len++;
            if (c == 0) dout_first = dout_o;
            if (sensor_req_o) reqs++;
            if (sync_err_o) errs++;
            if (c < 24 && fclk_o) fclk0++;
            if (dclk_o !== (c % 2 == 0)) dclk_bad++;
            if (c < 96) begin
                w_l0[c/24] = {w_l0[c/24][22:0], dout_o[0]};
                w_l1[c/24] = {w_l1[c/24][22:0], dout_o[1]};
            end
        end
        tp_sel_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sync_i = 1'b0; sync2_i = 1'b0; tp_sel_i = 1'b0;
        cfg_wr_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
        sensor_data_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout", {18'd0, dout_o}, 32'd0);
        chk("rst_clks", {29'd0, dclk_o, fclk_o, frame_active_o}, 32'd0);
        chk("rst_cnts", {line_cnt_o, frame_cnt_o}, 32'd0);
        chk("rst_flags", {29'd0, sleep_o, sensor_req_o, sync_err_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RAMP, single line
        cfg_write(8'h10, 16'h0260);
        start_sync1();
        run_frame(-1, -1, -1);
        chk("ramp_len", len, 32'd6144);
        chk("ramp_reqs", reqs, 32'd256);
        chk("ramp_msb_n1", {18'd0, dout_first}, 32'h3F00);
        chk("ramp_l1_w0", {8'd0, w_l1[0]}, 32'h100100);
        chk("ramp_l1_w3", {8'd0, w_l1[3]}, 32'h100103);
        chk("ramp_l0_w3", {8'd0, w_l0[3]}, 32'h000003);
        chk("ramp_fclk_bits", fclk0, 32'd12);
        chk("ramp_dclk_toggle_bad", dclk_bad, 32'd0);
        chk("ramp_errs", errs, 32'd0);
        chk("ramp_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);
        chk("ramp_end_dout", {18'd0, dout_o}, 32'd0);

        // Second edge 100 cycles into a frame
        start_sync1();
        run_frame(100, -1, -1);
        chk("err_pulses", errs, 32'd1);
        chk("err_len", len, 32'd6144);
        chk("err_frame_cnt", {16'd0, frame_cnt_o}, 32'd2);

        // Two lines, all-ones pattern
        cfg_write(8'h10, 16'h0320);
        @(negedge clk);
        sync2_i = 1'b1;
        #1;
        chk("l2_req_at_edge", {31'd0, sensor_req2}, 32'd1);
        len = 0; reqs = 1; dead = 0; line_first = 16'hFFFF; line_last = 16'hFFFF;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            sync2_i = 1'b0;
            #1;
            if (!frame_active2) break;
            if (c == 0) line_first = line_cnt2;
            line_last = line_cnt2;
            len++;
            if (sensor_req2) reqs++;
            if (dout2 == '0) dead++;
        end
        chk("l2_len", len, 32'd12292);
        chk("l2_reqs", reqs, 32'd512);
        chk("l2_dead", dead, 32'd4);
        chk("l2_line_first", {16'd0, line_first}, 32'd0);
        chk("l2_line_last", {16'd0, line_last}, 32'd1);
        chk("l2_frame_cnt", {16'd0, frame_cnt2}, 32'd1);

        // Sleep blocks frames
        cfg_write(8'h13, 16'hFFE0);
        #1;
        chk("sleep_set", {31'd0, sleep_o}, 32'd1);
        @(negedge clk);
        sync_i = 1'b1;
        #1;
        chk("sleep_sync_err", {31'd0, sync_err_o}, 32'd1);
        chk("sleep_no_req", {31'd0, sensor_req_o}, 32'd0);
        @(negedge clk);
        sync_i = 1'b0;
        #1;
        chk("sleep_no_frame", {31'd0, frame_active_o}, 32'd0);
        cfg_write(8'h13, 16'h7FE0);
        #1;
        chk("sleep_clear", {31'd0, sleep_o}, 32'd0);

        // Frame runs again, soft reset at word 10
        start_sync1();
        run_frame(-1, 240, -1);
        chk("srst_len", len, 32'd241);
        chk("srst_dout", {18'd0, dout_o}, 32'd0);
        chk("srst_clks", {29'd0, dclk_o, fclk_o, frame_active_o}, 32'd0);
        chk("srst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);

        // NORMAL (PAT_SEL cleared by soft reset), tp_sel from word 1
        sensor_data_i[15:0]  = 16'h8123;
        sensor_data_i[31:16] = 16'h5A5A;
        start_sync1();
        run_frame(-1, -1, 1);
        chk("norm_l0_w0", {8'd0, w_l0[0]}, 32'h008123);
        chk("norm_l1_w0", {8'd0, w_l1[0]}, 32'h105A5A);
        chk("tp_l0_w1", {8'd0, w_l0[1]}, 32'h000001);
        chk("tp_l1_w1", {8'd0, w_l1[1]}, 32'h100002);
        chk("norm_fclk_bits", fclk0, 32'd12);
        chk("norm_len", len, 32'd6144);
        chk("norm_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);

        // Code 0x15: PRBS-15 when built in, otherwise NORMAL
        cfg_write(8'h10, 16'h02A0);
        start_sync1();
        run_frame(-1, 30, -1);
`ifdef AFE_ROIC_PRBS_EN
        chk("prbs_l0_w0", {8'd0, w_l0[0]}, 32'h000006);
`else
        chk("code15_l0_w0", {8'd0, w_l0[0]}, 32'h008123);
`endif
        chk("code15_len", len, 32'd31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
